// File: rtl/tb_stim_sequencer.sv
// Stimulus sequencer: IDLE -> RUN -> DRAIN -> DONE with LFSR-driven stall/valid_off.
// Optional macro STALL_BURST_LIMIT_EN caps consecutive RUN stalls at MAX_STALL.
module tb_stim_sequencer #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter int                RUN_CYCLES   = 1024,
  parameter int                DRAIN_CYCLES = 16,
  parameter int                CNT_W        = 16,
  parameter int                MAX_STALL    = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             start,
  input  logic             stop_sim,
  input  logic [3:0]       stall_density,
  output logic             stall,
  output logic             valid_off,
  output logic             cmp_on,
  output logic             rd_1st_2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Galois taps for the 16-bit maximal-length polynomial; only LFSR_W=16 is meaningful.
  localparam logic [LFSR_W-1:0] TAPS       = 16'hB400;
  localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [3:0]        density_q, density_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              in_run, in_drain, stall_raw, stall_int;

  assign in_run    = (state_q == S_RUN);
  assign in_drain  = (state_q == S_DRAIN);
  assign lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
  assign stall_raw = in_run && (lfsr_q[3:0] < density_q);

`ifdef STALL_BURST_LIMIT_EN
  localparam int              BURST_W   = $clog2(MAX_STALL + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_STALL);

  logic [BURST_W-1:0] burst_q, burst_d;

  // A full burst forces one stall-free cycle, which also restarts the count.
  assign stall_int = stall_raw && (burst_q != BURST_MAX);

  always_comb begin
    burst_d = '0;
    if (in_run && (state_d == S_RUN) && stall_int) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign stall_int = stall_raw;
`endif

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    density_d = density_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !stop_sim) begin
          state_d   = S_RUN;
          density_d = stall_density;
          cnt_d     = '0;
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q + 1'b1;
        if (stop_sim || (cnt_q == RUN_LAST)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          rd_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      density_q <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      density_q <= density_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
    end
  end

  // Outputs decode from registered state only; DRAIN holds valid suppressed.
  assign stall     = stall_int;
  assign valid_off = in_run ? (~stall_int & lfsr_q[4]) : in_drain;
  assign cmp_on    = in_run | in_drain;
  assign busy      = in_run | in_drain;
  assign done      = (state_q == S_DONE);
  assign rd_1st_2  = rd_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_tb_stim_sequencer.sv
// Randomized bench for tb_stim_sequencer against a pass-level reference model.
module tb_tb_stim_sequencer;

  localparam int          RUN   = 8;
  localparam int          DRAIN = 4;
  localparam int          MAXS  = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk;
  logic        reset_;
  logic        start;
  logic        stop_sim;
  logic [3:0]  stall_density;
  logic        stall, valid_off, cmp_on, rd_1st_2, busy, done;
  logic [15:0] cycle_cnt;

  int          n_checks;
  int          n_fail;
  logic [15:0] lfsr_m;
  logic        exp_rd;
  logic        exp_done;

  tb_stim_sequencer #(
    .LFSR_W(16), .SEED(SEED), .RUN_CYCLES(RUN), .DRAIN_CYCLES(DRAIN),
    .CNT_W(16), .MAX_STALL(MAXS)
  ) dut (
    .clk(clk), .reset_(reset_), .start(start), .stop_sim(stop_sim),
    .stall_density(stall_density), .stall(stall), .valid_off(valid_off),
    .cmp_on(cmp_on), .rd_1st_2(rd_1st_2), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic e_vo,
                            input logic e_cmp, input logic e_busy, input logic e_done,
                            input logic e_rd, input int e_cnt);
    check_val({tag, ".stall"},     32'(stall),     32'(e_stall));
    check_val({tag, ".valid_off"}, 32'(valid_off), 32'(e_vo));
    check_val({tag, ".cmp_on"},    32'(cmp_on),    32'(e_cmp));
    check_val({tag, ".busy"},      32'(busy),      32'(e_busy));
    check_val({tag, ".done"},      32'(done),      32'(e_done));
    check_val({tag, ".rd_1st_2"},  32'(rd_1st_2),  32'(e_rd));
    check_val({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e_cnt));
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    if (x[0]) return (x >> 1) ^ 16'hB400;
    return x >> 1;
  endfunction

  // Entered and left on a falling edge with the DUT in IDLE or DONE.
  // stop_at: RUN cycle index carrying stop_sim (-1 none); abort_at: DRAIN cycle to reset in (-1 none).
  task automatic run_pass(input string tag, input int d, input int stop_at,
                          input int abort_at, input bit blocked_first);
    int run_len;
    int burst_m;
    int burst_obs;
    bit st_e;
    bit vo_e;
    if (blocked_first) begin
      start    = 1'b1;
      stop_sim = 1'b1;
      @(negedge clk);
      check_outs({tag, ".blocked"}, 0, 0, 0, 0, exp_done, exp_rd, 0);
    end
    start         = 1'b1;
    stop_sim      = 1'b0;
    stall_density = 4'(d);
    @(negedge clk);
    start         = 1'b0;
    stall_density = 4'($urandom_range(0, 15));
    run_len   = (stop_at >= 0 && stop_at < RUN) ? stop_at + 1 : RUN;
    burst_m   = 0;
    burst_obs = 0;
    for (int i = 0; i < run_len; i++) begin
      st_e = (int'(lfsr_m[3:0]) < d);
`ifdef STALL_BURST_LIMIT_EN
      if (burst_m == MAXS) st_e = 1'b0;
`endif
      burst_m = st_e ? burst_m + 1 : 0;
      vo_e    = !st_e && lfsr_m[4];
      check_outs($sformatf("%s.run%0d", tag, i), st_e, vo_e, 1, 1, 0, exp_rd, i);
      burst_obs = stall ? burst_obs + 1 : 0;
`ifdef STALL_BURST_LIMIT_EN
      check_val($sformatf("%s.burst%0d", tag, i), 32'(burst_obs <= MAXS), 32'd1);
`endif
      stop_sim = (i == stop_at);
      start    = 1'($urandom_range(0, 1));
      lfsr_m   = lfsr_adv(lfsr_m);
      @(negedge clk);
    end
    start = 1'b0;
    for (int j = 0; j < DRAIN; j++) begin
      check_outs($sformatf("%s.drain%0d", tag, j), 0, 1, 1, 1, 0, exp_rd, j);
      if (j == abort_at) begin
        reset_ = 1'b0;
        #1;
        check_outs({tag, ".abort"}, 0, 0, 0, 0, 0, 0, 0);
        lfsr_m   = SEED;
        exp_rd   = 1'b0;
        exp_done = 1'b0;
        stop_sim = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        return;
      end
      stop_sim = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    stop_sim = 1'b0;
    exp_rd   = 1'b1;
    exp_done = 1'b1;
    check_outs({tag, ".done"}, 0, 0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    int s;
    n_checks      = 0;
    n_fail        = 0;
    reset_        = 1'b0;
    start         = 1'b0;
    stop_sim      = 1'b0;
    stall_density = 4'd0;
    lfsr_m        = SEED;
    exp_rd        = 1'b0;
    exp_done      = 1'b0;
    #1;
    check_outs("reset_async", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_outs("reset_held", 0, 0, 0, 0, 0, 0, 0);
    reset_ = 1'b1;
    @(negedge clk);
    check_outs("idle", 0, 0, 0, 0, 0, 0, 0);

    run_pass("t4_idle_blk", 15, -1, -1, 1);
    for (int p = 0; p < 7; p++) run_pass($sformatf("t2_d15_p%0d", p), 15, -1, -1, 0);
    run_pass("t1_d0", 0, -1, -1, 0);
    run_pass("t3_stop3", int'($urandom_range(0, 15)), 3, -1, 0);
    run_pass("t4_done_blk", 5, -1, -1, 1);
    run_pass("t5_abort", 9, -1, 2, 0);
    check_outs("t5_idle", 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 8; p++) run_pass($sformatf("t5_rerun_p%0d", p), 15, -1, -1, 0);

    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) begin
        start    = 1'b0;
        stop_sim = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_outs($sformatf("gap%0d", r), 0, 0, 0, 0, exp_done, exp_rd, 0);
      end
      s = int'($urandom_range(0, 11));
      run_pass($sformatf("rnd%0d", r), int'($urandom_range(0, 15)),
               (s >= RUN) ? -1 : s, -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
